// File: rtl/gemm_2x2_stream_loader.sv
// rtl/gemm_2x2_stream_loader.sv - streams eight operand words into a 2x2 GEMM and hands back the result
//
// Purpose:
//   Collects A00..A11 then B00..B11 from a valid/ready word stream into pack
//   registers that drive an external 2x2 GEMM. It waits LATENCY edges for the
//   GEMM result, then captures it and presents it downstream. Only one job is
//   in flight at a time.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   upstream word valid
//   in_data    32-bit unsigned operand word
//   in_ready   loader accepts a word (LOAD state only)
//   mm_A       packed A to gemm, element [r][c] at bits 32*(2r+c) +: 32
//   mm_B       packed B to gemm, same packing
//   mm_out     packed C from gemm, same packing
//   res_valid  captured result available
//   res_data   captured C, same packing
//   res_ready  downstream accepts result
//   busy       high in any state other than LOAD
module gemm_2x2_stream_loader #(
  parameter int LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic [127:0] mm_A,
  output logic [127:0] mm_B,
  input  logic [127:0] mm_out,
  output logic         res_valid,
  output logic [127:0] res_data,
  input  logic         res_ready,
  output logic         busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     word_idx;
  logic [CW-1:0]  wait_cnt;
  logic [127:0]   pack_a;
  logic [127:0]   pack_b;
  logic           xfer;
  logic           capture;

  // State is already LOAD while rst is low, so in_ready is gated by rst
  // explicitly to keep it low during reset.
  assign in_ready  = (state == LOAD) && rst;
  assign busy      = (state != LOAD);
  assign res_valid = (state == HOLD);
  assign mm_A      = pack_a;
  assign mm_B      = pack_b;

  assign xfer    = in_valid && in_ready;
  assign capture = (state == WAIT) && (wait_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (xfer && (word_idx == 3'd7)) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD;
      word_idx <= 3'd0;
      wait_cnt <= '0;
      pack_a   <= '0;
      pack_b   <= '0;
      res_data <= '0;
    end else begin
      state <= state_nxt;

      // Index bit 2 selects B; the low two bits pick the element slot.
      if (xfer) begin
        word_idx <= word_idx + 3'd1;
        if (!word_idx[2]) pack_a[{word_idx[1:0], 5'd0} +: 32] <= in_data;
        else              pack_b[{word_idx[1:0], 5'd0} +: 32] <= in_data;
      end

      // The counter is loaded on the ISSUE edge, so the capture lands
      // exactly LATENCY edges after the gemm sampled its operands.
      if (state == ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if ((state == WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (capture) res_data <= mm_out;
    end
  end

endmodule

// File: tb/tb_gemm_2x2_stream_loader.sv
// tb/tb_gemm_2x2_stream_loader.sv - self-checking bench for gemm_2x2_stream_loader
module tb_gemm_2x2_stream_loader;

  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic [127:0] mm_A;
  logic [127:0] mm_B;
  logic [127:0] mm_out;
  logic         res_valid;
  logic [127:0] res_data;
  logic         res_ready;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0]  words [8];
  logic [127:0] pipe  [LAT];
  logic [127:0] junk;
  logic [127:0] held;

  gemm_2x2_stream_loader #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mm_A      (mm_A),
    .mm_B      (mm_B),
    .mm_out    (mm_out),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Environment gemm: samples its operands every edge, result appears LAT
  // edges later. Outside the operating window the bus carries junk.
  function automatic logic [127:0] gemm(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] c;
    for (int r = 0; r < 2; r++)
      for (int col = 0; col < 2; col++)
        c[32*(2*r+col) +: 32] = a[32*(2*r) +: 32] * b[32*col +: 32]
                              + a[32*(2*r+1) +: 32] * b[32*(2+col) +: 32];
    return c;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= gemm(mm_A, mm_B);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    junk <= {$urandom, $urandom, $urandom, $urandom};
  end

  assign mm_out = (res_valid || in_ready) ? junk : pipe[LAT-1];

  // Reference result computed directly from the word stream order.
  function automatic logic [127:0] ref_c();
    logic [127:0] c;
    logic [31:0]  s;
    for (int r = 0; r < 2; r++)
      for (int col = 0; col < 2; col++) begin
        s = 32'd0;
        for (int k = 0; k < 2; k++) s = s + words[2*r+k] * words[4+2*k+col];
        c[32*(2*r+col) +: 32] = s;
      end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    int waited = 0;
    repeat ($urandom_range(max_gap, 0)) tick();
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic load_job(input string tag, input int max_gap);
    for (int i = 0; i < 8; i++) send_word(words[i], max_gap);
    chk({tag, "_mm_A"}, mm_A, {words[3], words[2], words[1], words[0]});
    chk({tag, "_mm_B"}, mm_B, {words[7], words[6], words[5], words[4]});
    chk({tag, "_busy"}, 128'(busy), 128'd1);
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    bit bad = 1'b0;
    while (!res_valid && lat < 40) begin
      tick();
      lat++;
      if (!res_valid && in_ready) bad = 1'b1;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(LAT + 1));
    chk({tag, "_ready_low_in_wait"}, 128'(bad), 128'd0);
    chk({tag, "_res_data"}, res_data, ref_c());
  endtask

  task automatic rand_words();
    for (int i = 0; i < 8; i++) words[i] = $urandom;
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b0;
    #1;
    chk({tag, "_rst_in_ready"}, 128'(in_ready), 128'd0);
    chk({tag, "_rst_res_valid"}, 128'(res_valid), 128'd0);
    chk({tag, "_rst_busy"}, 128'(busy), 128'd0);
    chk({tag, "_rst_mm_A"}, mm_A, 128'd0);
    chk({tag, "_rst_res_data"}, res_data, 128'd0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    bit seen;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    res_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_res_valid", 128'(res_valid), 128'd0);
    chk("rst_mm_A", mm_A, 128'd0);
    chk("rst_mm_B", mm_B, 128'd0);
    chk("rst_res_data", res_data, 128'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);
    tick();

    // Back-to-back 1..8
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) words[i] = 32'(i + 1);
    load_job("seq", 0);
    wait_result("seq");
    chk("seq_const", res_data, {32'd50, 32'd43, 32'd22, 32'd19});
    tick();
    chk("seq_pulse_end", 128'(res_valid), 128'd0);
    chk("seq_ready_again", 128'(in_ready), 128'd1);

    // Identity A, gappy stream
    words = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd9, 32'd10, 32'd11, 32'd12};
    load_job("ident", 3);
    wait_result("ident");
    chk("ident_const", res_data, {32'd12, 32'd11, 32'd10, 32'd9});
    tick();

    // Wraparound mod 2^32
    words = '{32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0};
    load_job("wrap", 1);
    wait_result("wrap");
    chk("wrap_const", res_data, {96'd0, 32'hFFFF_FFFE});
    tick();

    // Back-pressure in HOLD for 10 cycles with upstream pushing
    res_ready = 1'b0;
    rand_words();
    load_job("hold", 2);
    wait_result("hold");
    held     = ref_c();
    in_valid = 1'b1;
    in_data  = $urandom;
    stable   = 1'b1;
    repeat (10) begin
      tick();
      if (!res_valid || in_ready || res_data !== held) stable = 1'b0;
    end
    chk("hold_stable", 128'(stable), 128'd1);
    res_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("hold_release_in_ready", 128'(in_ready), 128'd1);
    chk("hold_release_res_valid", 128'(res_valid), 128'd0);
    chk("hold_res_data_kept", res_data, held);

    // Reset in WAIT, then after 3 words of the next job
    rand_words();
    load_job("abort", 0);
    repeat (3) tick();
    pulse_reset("abort_wait");
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("abort_no_result", 128'(seen), 128'd0);
    rand_words();
    for (int i = 0; i < 3; i++) send_word(words[i], 1);
    pulse_reset("abort_load");
    tick();
    rand_words();
    load_job("fresh", 2);
    wait_result("fresh");
    tick();

    // Two consecutive jobs, res_ready tied high
    for (int j = 0; j < 2; j++) begin
      rand_words();
      load_job("b2b", 0);
      wait_result("b2b");
      tick();
      chk("b2b_one_cycle", 128'(res_valid), 128'd0);
    end

    // Random jobs with random gaps
    for (int j = 0; j < 4; j++) begin
      rand_words();
      load_job("rnd", 4);
      wait_result("rnd");
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
